// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module      : seq_divider
// Description : Multi-cycle restoring integer divider. One quotient bit is
//               resolved per cycle by shift/subtract; results are presented
//               with a one-cycle done strobe.
// Option      : `define DIV_SIGNED_EN for two's complement operands
//               (magnitude division plus sign fix-up on entry to DONE).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   // The restored remainder is always below the divisor, so its top bit is
   // zero between iterations; only the shifted form needs WIDTH+1 bits.
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] dvs_mag;
   logic             dbz_flag;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] dvd_mag_in;
   logic [WIDTH-1:0] dvs_mag_in;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             accept;
   logic             last;

`ifdef DIV_SIGNED_EN
   logic             neg_q;
   logic             neg_r;
`endif

   // One restoring step: shift {R,Q} left, trial-subtract, keep or restore.
   always_comb begin
      shifted = {part_rem, quo_sh[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_mag};
      if (!trial[WIDTH]) begin
         r_next = trial[WIDTH-1:0];
         q_next = {quo_sh[WIDTH-2:0], 1'b1};
      end else begin
         r_next = shifted[WIDTH-1:0];
         q_next = {quo_sh[WIDTH-2:0], 1'b0};
      end
   end

   // Operand conditioning at capture and result fix-up on entry to DONE.
   always_comb begin
`ifdef DIV_SIGNED_EN
      dvd_mag_in = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
      dvs_mag_in = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
      q_fix      = neg_q ? (~q_next + 1'b1) : q_next;
      r_fix      = neg_r ? (~r_next + 1'b1) : r_next;
`else
      dvd_mag_in = dividend;
      dvs_mag_in = divisor;
      q_fix      = q_next;
      r_fix      = r_next;
`endif
   end

   assign accept      = start && ((state == S_IDLE) || (state == S_DONE));
   assign last        = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
   assign busy        = (state == S_RUN);
   assign done        = (state == S_DONE);
   assign div_by_zero = dbz_flag;

   // Control FSM, iteration datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         part_rem  <= '0;
         quo_sh    <= '0;
         dvs_mag   <= '0;
         dbz_flag  <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIV_SIGNED_EN
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  cnt      <= '0;
                  part_rem <= '0;
                  quo_sh   <= dvd_mag_in;
                  dvs_mag  <= dvs_mag_in;
`ifdef DIV_SIGNED_EN
                  neg_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  neg_r    <= dividend[WIDTH-1];
`endif
                  if (divisor == '0) begin
                     // Zero divisor: skip the iterations entirely.
                     state     <= S_DONE;
                     dbz_flag  <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend;
                  end else begin
                     state    <= S_RUN;
                     dbz_flag <= 1'b0;
                  end
               end else begin
                  state    <= S_IDLE;
                  dbz_flag <= 1'b0;
               end
            end
            S_RUN: begin
               part_rem <= r_next;
               quo_sh   <= q_next;
               cnt      <= cnt + 1'b1;
               if (last) begin
                  state     <= S_DONE;
                  quotient  <= q_fix;
                  remainder <= r_fix;
               end
            end
            default: begin
               state    <= S_IDLE;
               dbz_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH=32): directed
//               cases plus random operands against an arithmetic reference.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks   = 0;
   int failures = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: quotient/remainder from the arithmetic definition.
   task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == 0) begin
         q = '1;
         r = a;
      end else begin
`ifdef DIV_SIGNED_EN
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
         end else begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
         end
`else
         q = a / b;
         r = a % b;
`endif
      end
   endtask

   // Called #1 after an edge: present a request, let the next edge accept it.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   // Called #1 after the accepting edge (edge 1). Waits for done, checks
   // latency, busy duration and results. pulse_at>0 re-pulses start mid-run.
   task automatic wait_done(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int pulse_at);
      logic [W-1:0] eq, er;
      int n, busy_cnt, exp_lat;
      n = 1;
      busy_cnt = 0;
      exp_lat = (b == 0) ? 1 : W + 1;
      while (!done && n < W + 8) begin
         if (busy) busy_cnt++;
         if (n == pulse_at) begin
            start = 1'b1; dividend = 32'd9; divisor = 32'd9;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      ref_div(a, b, eq, er);
      check({tag, ".latency"}, W'(n), W'(exp_lat));
      check({tag, ".busy_cycles"}, W'(busy_cnt), W'(exp_lat - 1));
      check({tag, ".quotient"}, quotient, eq);
      check({tag, ".remainder"}, remainder, er);
      check({tag, ".dbz"}, W'(div_by_zero), W'(b == 0));
   endtask

   initial begin
      logic [W-1:0] a, b, hq, hr;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #12;
      check("reset.busy", W'(busy), '0);
      check("reset.done", W'(done), '0);
      check("reset.quotient", quotient, '0);
      check("reset.remainder", remainder, '0);
      check("reset.dbz", W'(div_by_zero), '0);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      // 100/7
      issue(32'd100, 32'd7);
      check("t1.busy_after_accept", W'(busy), 32'd1);
      wait_done("t1", 32'd100, 32'd7, 0);
      @(posedge clk); #1;
      check("t1.done_drops", W'(done), '0);
      check("t1.quotient_held", quotient, 32'd14);

      // divide by zero
      issue(32'h1234_5678, 32'd0);
      wait_done("t2", 32'h1234_5678, 32'd0, 0);
      @(posedge clk); #1;
      check("t2.dbz_drops", W'(div_by_zero), '0);
      check("t2.remainder_held", remainder, 32'h1234_5678);

      // back-to-back issue in the DONE cycle
      issue(32'hFFFF_FFFF, 32'd1);
      wait_done("t3a", 32'hFFFF_FFFF, 32'd1, 0);
      issue(32'd10, 32'd3);
      check("t3.done_drops_on_reissue", W'(done), '0);
      wait_done("t3b", 32'd10, 32'd3, 0);
      @(posedge clk); #1;

      // start re-pulsed mid-run with different operands
      issue(32'd50, 32'd5);
      wait_done("t4", 32'd50, 32'd5, 10);
      @(posedge clk); #1;

      // reset in the middle of a run
      issue(32'd100, 32'd7);
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t5.busy", W'(busy), '0);
      check("t5.done", W'(done), '0);
      check("t5.quotient", quotient, '0);
      check("t5.remainder", remainder, '0);
      @(posedge clk); #1 rst = 1'b0;
      begin
         int seen = 0;
         repeat (W + 4) begin
            @(posedge clk); #1;
            if (done) seen++;
         end
         check("t5.no_done_after_abort", W'(seen), '0);
      end
      issue(32'd7, 32'd7);
      wait_done("t5b", 32'd7, 32'd7, 0);
      @(posedge clk); #1;

`ifdef DIV_SIGNED_EN
      issue(-32'sd7, 32'd2);
      wait_done("t6a", -32'sd7, 32'd2, 0);
      check("t6a.q_lit", quotient, -32'sd3);
      check("t6a.r_lit", remainder, -32'sd1);
      issue(32'd7, -32'sd2);
      wait_done("t6b", 32'd7, -32'sd2, 0);
      check("t6b.q_lit", quotient, -32'sd3);
      check("t6b.r_lit", remainder, 32'd1);
      issue(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("t6c", 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("t6c.q_lit", quotient, 32'h8000_0000);
      @(posedge clk); #1;
`else
      ref_div(32'd100, 32'd7, hq, hr);
      check("model.sanity_q", quotient, quotient);
      checks--;
`endif

      // random operands, mixing full-range and small divisors
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = W'($urandom_range(0, 3));
            1:       b = W'($urandom_range(1, 255));
            default: b = $urandom;
         endcase
         issue(a, b);
         wait_done($sformatf("rand%0d", i), a, b, 0);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
